// File: rtl/idct_coef_gen.sv
// rtl/idct_coef_gen.sv - streaming 8-point IDCT basis coefficient generator
// Single (x,u) lookups or 64-item bursts through a two-stage fold/lookup pipeline.
module idct_coef_gen #(
    parameter int FRAC_BITS = 9,
    parameter int COEF_W    = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [2:0]               req_x,
    input  logic [2:0]               req_u,
    input  logic                     req_burst,
    input  logic                     dc_scale_en,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [COEF_W-1:0] out_coef,
    output logic [2:0]               out_x,
    output logic [2:0]               out_u,
    output logic                     out_last,
    output logic                     busy
);

    localparam int SH = 15 - FRAC_BITS;

    typedef enum logic {IDLE, BURST} state_t;

    state_t     state, state_nxt;
    logic [5:0] n, n_nxt;
    logic       dc_hold;
    logic       stall;

    logic       iss_valid;
    logic [2:0] iss_x, iss_u;
    logic       iss_last, iss_dc;

    logic       s1_valid, s1_neg, s1_dc, s1_last;
    logic [3:0] s1_m;
    logic [2:0] s1_x, s1_u;

    logic [4:0] odd, k;
    logic [3:0] m;
    logic       neg;

    logic [16:0]       mag, rnd;
    logic [COEF_W-1:0] r_ext, coef_nxt;

    assign stall = out_valid & ~out_ready;
    assign busy  = (state == BURST) | s1_valid | out_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            n       <= 6'd0;
            dc_hold <= 1'b0;
        end else begin
            state <= state_nxt;
            n     <= n_nxt;
            if (state == IDLE && req_valid && req_ready && req_burst)
                dc_hold <= dc_scale_en;
        end
    end

    always_comb begin
        state_nxt = state;
        n_nxt     = n;
        req_ready = 1'b0;
        iss_valid = 1'b0;
        iss_x     = req_x;
        iss_u     = req_u;
        iss_last  = 1'b1;
        iss_dc    = dc_scale_en;
        case (state)
            IDLE: begin
                req_ready = ~stall;
                if (req_valid && !stall) begin
                    if (req_burst) begin
                        state_nxt = BURST;
                        n_nxt     = 6'd0;
                    end else begin
                        iss_valid = 1'b1;
                    end
                end
            end
            BURST: begin
                iss_x    = n[5:3];
                iss_u    = n[2:0];
                iss_last = (n == 6'd63);
                iss_dc   = dc_hold;
                if (!stall) begin
                    iss_valid = 1'b1;
                    n_nxt     = n + 6'd1;
                    if (n == 6'd63)
                        state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Fold the phase k onto the first quarter wave 0..8 and remember the sign.
    assign odd = {1'b0, iss_x, 1'b1};
    assign k   = odd * {2'b00, iss_u};

    always_comb begin
        m   = 4'd0;
        neg = 1'b0;
        if (k <= 5'd8) begin
            m = k[3:0];
        end else if (k <= 5'd16) begin
            m   = 4'(5'd16 - k);
            neg = 1'b1;
        end else if (k <= 5'd24) begin
            m   = 4'(k - 5'd16);
            neg = 1'b1;
        end else begin
            m = 4'(6'd32 - {1'b0, k});
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_m     <= 4'd0;
            s1_neg   <= 1'b0;
            s1_dc    <= 1'b0;
            s1_x     <= 3'd0;
            s1_u     <= 3'd0;
            s1_last  <= 1'b0;
        end else if (!stall) begin
            s1_valid <= iss_valid;
            if (iss_valid) begin
                s1_m    <= m;
                s1_neg  <= neg;
                s1_dc   <= iss_dc & (iss_u == 3'd0);
                s1_x    <= iss_x;
                s1_u    <= iss_u;
                s1_last <= iss_last;
            end
        end
    end

    always_comb begin
        mag = 17'd0;
        if (s1_dc) begin
            mag = 17'd23170;
        end else begin
            case (s1_m)
                4'd0:    mag = 17'd32768;
                4'd1:    mag = 17'd32138;
                4'd2:    mag = 17'd30274;
                4'd3:    mag = 17'd27246;
                4'd4:    mag = 17'd23170;
                4'd5:    mag = 17'd18205;
                4'd6:    mag = 17'd12540;
                4'd7:    mag = 17'd6393;
                default: mag = 17'd0;
            endcase
        end
    end

    generate
        if (SH == 0) begin : g_full
            assign rnd = mag;
        end else begin : g_round
            assign rnd = (mag + 17'(1 << (SH - 1))) >> SH;
        end
    endgenerate

    assign r_ext    = COEF_W'(rnd);
    assign coef_nxt = s1_neg ? (~r_ext + 1'b1) : r_ext;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_coef  <= '0;
            out_x     <= 3'd0;
            out_u     <= 3'd0;
            out_last  <= 1'b0;
        end else if (!stall) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_coef <= coef_nxt;
                out_x    <= s1_x;
                out_u    <= s1_u;
                out_last <= s1_last;
            end
        end
    end

endmodule

// File: tb/tb_idct_coef_gen.sv
// tb/tb_idct_coef_gen.sv - randomized scoreboard bench for idct_coef_gen
module tb_idct_coef_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic req_valid = 0, req_burst = 0, dc_scale_en = 0, out_ready = 1;
    logic [2:0] req_x = 0, req_u = 0;
    logic req_ready, out_valid, out_last, busy;
    logic signed [15:0] out_coef;
    logic [2:0] out_x, out_u;

    logic h_valid = 0, h_dc = 0;
    logic [2:0] h_x = 0, h_u = 0;
    logic h_ready, h_out_valid, h_out_last, h_busy;
    logic signed [17:0] h_coef;
    logic [2:0] h_out_x, h_out_u;

    idct_coef_gen #(.FRAC_BITS(9), .COEF_W(16)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_u(req_u), .req_burst(req_burst), .dc_scale_en(dc_scale_en),
        .out_valid(out_valid), .out_ready(out_ready), .out_coef(out_coef),
        .out_x(out_x), .out_u(out_u), .out_last(out_last), .busy(busy));

    idct_coef_gen #(.FRAC_BITS(15), .COEF_W(18)) dut_h (
        .clk(clk), .rst(rst), .req_valid(h_valid), .req_ready(h_ready),
        .req_x(h_x), .req_u(h_u), .req_burst(1'b0), .dc_scale_en(h_dc),
        .out_valid(h_out_valid), .out_ready(1'b1), .out_coef(h_coef),
        .out_x(h_out_x), .out_u(h_out_u), .out_last(h_out_last), .busy(h_busy));

    typedef struct {int coef; int x; int u; int last; real fl;} item_t;
    item_t exp_q[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: fold the cosine phase onto the Q15 table, then round half up.
    function automatic int model_coef(input int x, input int u, input bit dc, input int fb);
        int tbl[9] = '{32768, 32138, 30274, 27246, 23170, 18205, 12540, 6393, 0};
        int kk, mm, mag, r;
        bit ng;
        kk = ((2 * x + 1) * u) % 32;
        if (kk <= 8)       begin mm = kk;      ng = 0; end
        else if (kk <= 16) begin mm = 16 - kk; ng = 1; end
        else if (kk <= 24) begin mm = kk - 16; ng = 1; end
        else               begin mm = 32 - kk; ng = 0; end
        mag = (u == 0 && dc) ? 23170 : tbl[mm];
        r = (fb == 15) ? mag : ((mag + (1 << (14 - fb))) >> (15 - fb));
        return ng ? -r : r;
    endfunction

    function automatic real model_float(input int x, input int u, input bit dc);
        real c0;
        c0 = (u == 0 && dc) ? 1.0 / $sqrt(2.0) : 1.0;
        return c0 * $cos((2.0 * x + 1.0) * u * 3.14159265358979 / 16.0) * 512.0;
    endfunction

    function automatic void push_item(input int x, input int u, input bit dc, input int last);
        item_t it;
        it.coef = model_coef(x, u, dc, 9);
        it.x = x; it.u = u; it.last = last;
        it.fl = model_float(x, u, dc);
        exp_q.push_back(it);
    endfunction

    bit prev_stall = 0;
    logic [23:0] held;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                checks++;
                if ({out_valid, out_coef, out_x, out_u, out_last} != held) begin
                    errors++;
                    $display("FAIL stall_hold: got %h expected %h",
                             {out_valid, out_coef, out_x, out_u, out_last}, held);
                end
            end
            if (req_valid && req_ready) begin
                if (req_burst) begin
                    for (int i = 0; i < 64; i++)
                        push_item(i / 8, i % 8, dc_scale_en, (i == 63) ? 1 : 0);
                end else begin
                    push_item(int'(req_x), int'(req_u), dc_scale_en, 1);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_item: got x=%0d u=%0d expected none", out_x, out_u);
                end else begin
                    item_t e;
                    int a;
                    real d;
                    e = exp_q.pop_front();
                    a = out_coef;
                    if (a != e.coef || int'(out_x) != e.x || int'(out_u) != e.u || int'(out_last) != e.last) begin
                        errors++;
                        $display("FAIL item: got coef=%0d x=%0d u=%0d last=%0d expected coef=%0d x=%0d u=%0d last=%0d",
                                 a, out_x, out_u, out_last, e.coef, e.x, e.u, e.last);
                    end
                    checks++;
                    d = a - e.fl;
                    if (d > 1.0 || d < -1.0) begin
                        errors++;
                        $display("FAIL float_tol: got %0d expected %f", a, e.fl);
                    end
                end
            end
            prev_stall = out_valid && !out_ready;
            held = {out_valid, out_coef, out_x, out_u, out_last};
        end
    end

    task automatic wait_accept(output bit ok);
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (req_ready) begin ok = 1; break; end
        end
        chk("accept_timeout", int'(ok), 1);
    endtask

    task automatic single(input int x, input int u, input bit dc, input int lit);
        bit ok;
        @(posedge clk); #1;
        req_valid = 1; req_burst = 0; req_x = 3'(x); req_u = 3'(u); dc_scale_en = dc;
        wait_accept(ok);
        @(posedge clk); #1;
        req_valid = 0;
        @(negedge clk);
        chk("lat_cycle1_valid", int'(out_valid), 0);
        @(negedge clk);
        chk("lat_cycle2_valid", int'(out_valid), 1);
        chk("single_coef", int'(out_coef), lit);
        chk("single_last", int'(out_last), 1);
    endtask

    task automatic single_h(input int x, input int u, input bit dc, input int lit);
        @(posedge clk); #1;
        h_valid = 1; h_x = 3'(x); h_u = 3'(u); h_dc = dc;
        @(posedge clk); #1;
        h_valid = 0;
        @(negedge clk);
        chk("h_lat_cycle1_valid", int'(h_out_valid), 0);
        @(negedge clk);
        chk("h_valid", int'(h_out_valid), 1);
        chk("h_coef", int'(h_coef), lit);
    endtask

    task automatic burst(input bit rand_ready, input bit dc);
        bit ok;
        int got, gaps, rr_bad, started;
        bit done;
        got = 0; gaps = 0; rr_bad = 0; started = 0; done = 0;
        @(posedge clk); #1;
        req_valid = 1; req_burst = 1; dc_scale_en = dc;
        wait_accept(ok);
        @(posedge clk); #1;
        req_valid = 0; req_burst = 0; dc_scale_en = ~dc;
        for (int i = 0; i < 1000 && !done; i++) begin
            if (i > 0) begin
                @(posedge clk); #1;
            end
            out_ready = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
            @(negedge clk);
            if (!(out_valid && (int'(out_x) * 8 + int'(out_u)) > 61) && req_ready)
                rr_bad++;
            if (out_valid && out_ready) begin
                got++;
                started = 1;
                if (out_last) done = 1;
            end else if (started && !rand_ready) begin
                gaps++;
            end
        end
        out_ready = 1;
        chk("burst_done", int'(done), 1);
        chk("burst_count", got, 64);
        chk("burst_req_ready_low", rr_bad, 0);
        if (!rand_ready) chk("burst_gaps", gaps, 0);
    endtask

    initial begin
        bit ok;
        bit drained;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_out_coef", int'(out_coef), 0);
        chk("rst_out_last", int'(out_last), 0);
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        chk("rst_req_ready", int'(req_ready), 1);

        single(0, 1, 0, 502);
        single(3, 2, 0, -473);
        single(7, 7, 0, -100);
        single(2, 4, 0, -362);
        single(5, 6, 0, 473);
        single(4, 0, 1, 362);
        single(4, 0, 0, 512);

        burst(0, 1);
        burst(1, 0);

        @(posedge clk); #1;
        req_valid = 1; req_burst = 1; dc_scale_en = 0;
        wait_accept(ok);
        @(posedge clk); #1;
        req_valid = 0; req_burst = 0;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (out_valid && out_x == 3'd2 && out_u == 3'd4) begin ok = 1; break; end
        end
        chk("reach_n20", int'(ok), 1);
        rst = 1;
        #1;
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_busy", int'(busy), 0);
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        chk("post_rst_req_ready", int'(req_ready), 1);
        chk("post_rst_quiet", int'(out_valid), 0);
        repeat (3) @(negedge clk);
        chk("post_rst_still_quiet", int'(out_valid), 0);
        single(1, 1, 0, 426);

        single_h(0, 0, 0, 32768);
        single_h(0, 4, 0, 23170);
        single_h(1, 4, 0, -23170);

        for (int i = 0; i < 600; i++) begin
            @(posedge clk); #1;
            req_valid   = ($urandom_range(0, 1) != 0);
            req_burst   = ($urandom_range(0, 24) == 0);
            req_x       = 3'($urandom_range(0, 7));
            req_u       = 3'($urandom_range(0, 7));
            dc_scale_en = ($urandom_range(0, 1) != 0);
            out_ready   = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk); #1;
        req_valid = 0; req_burst = 0; out_ready = 1;
        drained = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy) begin drained = 1; break; end
        end
        chk("drain", int'(drained), 1);
        chk("queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
